toggle_bank_arbiter: RTL and testbench
======================================

# toggle_bank_arbiter

Round-robin arbiter that shares one WIDTH-bit bank of toggle flip-flops among NREQ requesters. Each requester presents a toggle mask. The arbiter grants one requester at a time, applies that mask to the bank (q <= q ^ mask), and returns a one-cycle acknowledge. It sits between the control-path requesters and the shared toggle-register state, and it is the only writer of that state.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, width of the shared toggle bank

Ports:
- clk  input  1  rising-edge clock; the block uses one clock
- rst  input  1  reset; asynchronous, active-high
- req  input  NREQ  per-requester request level
- mask  input  NREQ*WIDTH  toggle masks; requester i owns bits [i*WIDTH +: WIDTH]
- clr  input  1  synchronous clear of the bank
- grant  output  NREQ  registered, one-hot or zero
- ack  output  NREQ  one-cycle pulse on the requester whose mask was applied
- q  output  WIDTH  bank state
- busy  output  1  high in GRANT and APPLY

## Operation
- States:
  - IDLE (reset state)
  - GRANT
  - APPLY
- IDLE:
  - If any req bit is high, pick a winner round-robin starting at index ptr.
  - Register grant = onehot(winner) and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - If req[winner] is still high: q <= q ^ mask[winner], set ack[winner] for the next cycle, go to APPLY.
  - If req[winner] has dropped: abort. No toggle, no ack, grant cleared, go to IDLE. ptr still advances past the winner.
- APPLY:
  - grant is 0 and ack is high for one cycle.
  - ptr <= (winner+1) mod NREQ.
  - If any req is high (evaluated with the updated ptr), pick a new winner and go to GRANT. Otherwise go to IDLE.
- Requester rule: a requester must deassert req in its ack cycle. If req is still high there, it is treated as a new request. Round-robin order prevents starvation.
- clr:
  - Takes effect in any state: q <= 0 on the next edge.
  - If clr coincides with an apply edge, clr wins. The mask is discarded, but ack is still issued and ptr still advances.
  - clr does not change FSM state.
- mask width rule: plain per-bit XOR; no carry and no saturation.
- Mask of all zeros: legal. Full handshake runs and q is unchanged.
- ptr width: clog2(NREQ). Wraps from NREQ-1 to 0.

## Timing
- Reset values: q=0, grant=0, ack=0, busy=0, state=IDLE, ptr=0 (req[0] has first priority). Reset asserted mid-transaction returns all of these immediately, with no pending toggle.
- Request-to-grant latency: req high before edge n gives grant high from edge n to n+1.
- Mask sampling: mask is sampled at edge n+1 (end of GRANT). The requester must hold mask stable while grant is high.
- Apply timing: q updates at edge n+1. ack is high from edge n+1 to n+2, aligned with the new q.
- Throughput:
  - Back-to-back grants to different requesters: one toggle every 2 cycles (GRANT, APPLY, GRANT, ...).
  - Isolated request: IDLE→GRANT→APPLY→IDLE takes 3 cycles.
- Signal timing: grant, ack, busy and q are registered outputs with no combinational input-to-output path.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, GRANT, APPLY) as a 2-bit typedef
  - a function rr_pick(req, ptr) returning the winner index and a valid bit
  - localparam PTR_W = clog2(NREQ)
- One natural sub-module, toggle_bank. It is a WIDTH-bit register with inputs en, tmask, clr and rst (async), and output q. It performs the XOR update; clr has priority over en.
- The arbiter FSM, ptr and grant/ack registers stay in the top module.

## Test plan
- Reset release, NREQ=4, WIDTH=8; req=4'b0001, mask0=8'hA5 → grant=0001 at cycle 1, ack[0] at cycle 2, q=8'hA5 at cycle 2, busy low by cycle 3.
- All four req held high with masks 01,02,04,08 → grant order 0,1,2,3,0 (each requester drops req on ack, then re-raises); q after four acks = 8'h0F; each toggle spaced 2 cycles apart.
- req[2] drops during GRANT → no ack, q unchanged, ptr=3; next req=4'b0101 is granted to index 0 (search wraps 3→0).
- clr asserted at the same edge as the apply of mask 8'hFF with q=8'h3C → q=8'h00, ack still pulses, ptr advances.
- Async rst asserted mid-GRANT (not edge-aligned) → grant, ack, busy and q all go to 0 immediately; after release, the first request is served starting from index 0.
- Zero mask on req[1] with q=8'h55 → full handshake completes with ack[1], and q stays 8'h55.

Source files
------------

// File: rtl/toggle_bank_arbiter_pkg.sv
// Shared types and helpers for the toggle bank arbiter: FSM state encoding,
// the round-robin pick result, and the round-robin search function.
package toggle_bank_arbiter_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 8;
    localparam int PTR_W     = $clog2(NREQ_DEF);
    localparam int MAX_NREQ  = 8;
    localparam int MAX_PTR_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        APPLY = 2'd2
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [MAX_PTR_W-1:0] idx;
    } pick_t;

    // Lowest offset from ptr wins; walking offsets downward lets it overwrite last.
    function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0]  req,
                                      input logic [MAX_PTR_W-1:0] ptr,
                                      input int                   nreq);
        pick_t                r;
        logic [MAX_PTR_W-1:0] j;
        int                   s;
        r = '0;
        for (int k = MAX_NREQ - 1; k >= 0; k--) begin
            s = (int'(ptr) + k) % nreq;
            j = MAX_PTR_W'(s);
            if (k < nreq && req[j]) begin
                r.valid = 1'b1;
                r.idx   = j;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/toggle_bank_arbiter_if.sv
// Request/grant bus between the requesters (master) and the toggle bank arbiter (slave).
interface toggle_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] mask;
    logic                  clr;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      q;
    logic                  busy;

    modport master (output req, mask, clr, input grant, ack, q, busy);
    modport slave  (input req, mask, clr, output grant, ack, q, busy);

endinterface

// File: rtl/toggle_bank_arbiter_toggle_bank.sv
// Shared WIDTH-bit toggle register: q ^= tmask when en, clr forces zero and wins over en.
module toggle_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] tmask,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q ^ tmask;
        end
    end

endmodule

// File: rtl/toggle_bank_arbiter.sv
// Round-robin arbiter granting one requester at a time to toggle the shared bank.
//   state | meaning
//   IDLE  | no owner; search for a winner starting at ptr
//   GRANT | winner holds grant; apply its mask at the next edge unless req dropped
//   APPLY | ack pulse with the new q; ptr already past winner, search again
module toggle_bank_arbiter
    import toggle_bank_arbiter_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input logic                  clk,
    input logic                  rst,
    toggle_bank_arbiter_if.slave bus
);

    localparam int PTR_BITS = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t              state, state_n;
    logic [PTR_BITS-1:0] ptr, ptr_n;
    logic [PTR_BITS-1:0] win, win_n;
    logic [NREQ-1:0]     grant_r, grant_n;
    logic [NREQ-1:0]     ack_r, ack_n;
    logic                busy_r, busy_n;
    logic                apply_en;
    logic [WIDTH-1:0]    tmask;
    pick_t               pick;

    always_comb pick  = rr_pick(MAX_NREQ'(bus.req), MAX_PTR_W'(ptr), NREQ);
    always_comb tmask = bus.mask[int'(win)*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            win     <= '0;
            grant_r <= '0;
            ack_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            win     <= win_n;
            grant_r <= grant_n;
            ack_r   <= ack_n;
            busy_r  <= busy_n;
        end
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        win_n    = win;
        grant_n  = '0;
        ack_n    = '0;
        apply_en = 1'b0;
        case (state)
            IDLE, APPLY: begin
                if (pick.valid) begin
                    win_n          = PTR_BITS'(pick.idx);
                    grant_n[win_n] = 1'b1;
                    state_n        = GRANT;
                end else begin
                    state_n = IDLE;
                end
            end
            GRANT: begin
                // ptr moves past the winner whether the toggle happens or is aborted
                ptr_n = (win == PTR_BITS'(NREQ - 1)) ? '0 : win + 1'b1;
                if (bus.req[win]) begin
                    apply_en   = 1'b1;
                    ack_n[win] = 1'b1;
                    state_n    = APPLY;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    toggle_bank #(.WIDTH(WIDTH)) u_bank (
        .clk   (clk),
        .rst   (rst),
        .en    (apply_en),
        .tmask (tmask),
        .clr   (bus.clr),
        .q     (bus.q)
    );

    assign bus.grant = grant_r;
    assign bus.ack   = ack_r;
    assign bus.busy  = busy_r;

endmodule

// File: tb/tb_toggle_bank_arbiter.sv
// Self-checking bench for toggle_bank_arbiter: directed scenarios plus randomized
// requester traffic, compared every cycle against a transaction-level reference.
module tb_toggle_bank_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    toggle_bank_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

    toggle_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: who holds grant, who is acked, next-search start and bank value.
    int         m_g, m_a, m_ptr;
    logic [7:0] m_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        return (i >= 0) ? 4'(1 << i) : 4'h0;
    endfunction

    task automatic model_reset();
        m_g = -1; m_a = -1; m_ptr = 0; m_q = 8'h00;
    endtask

    // One clock edge: an outstanding grant resolves (apply or abort); otherwise the
    // requests are searched round-robin from m_ptr for a new owner.
    task automatic model_step(input logic [3:0] r, input logic [31:0] m, input logic c);
        int prev;
        bit applied;
        prev = m_g; applied = 0; m_g = -1; m_a = -1;
        if (prev >= 0) begin
            if (r[prev]) begin
                m_a = prev;
                applied = 1;
            end
            m_ptr = (prev + 1) % 4;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (r[(m_ptr + k) % 4]) begin
                    m_g = (m_ptr + k) % 4;
                    break;
                end
            end
        end
        if (c) m_q = 8'h00;
        else if (applied) m_q = m_q ^ m[prev*8 +: 8];
    endtask

    task automatic check_outputs();
        chk("step.grant", bus.grant, oh(m_g));
        chk("step.ack",   bus.ack,   oh(m_a));
        chk("step.q",     bus.q,     m_q);
        chk("step.busy",  bus.busy,  (m_g >= 0) || (m_a >= 0));
    endtask

    task automatic tick(input logic [3:0] r, input logic [31:0] m, input logic c);
        bus.req = r; bus.mask = m; bus.clr = c;
        @(posedge clk);
        model_step(r, m, c);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0; bus.mask = '0; bus.clr = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst.grant", bus.grant, 0);
        chk("rst.ack",   bus.ack,   0);
        chk("rst.q",     bus.q,     0);
        chk("rst.busy",  bus.busy,  0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [3:0]  gq[$];
        int          ack_cyc[$];
        logic [3:0]  pend;
        logic [7:0]  pm[4];
        logic [31:0] mm;
        logic [3:0]  rr;

        // single request after reset
        do_reset();
        tick(4'b0001, 32'h0000_00A5, 0);
        chk("t1.grant", bus.grant, 4'b0001);
        tick(4'b0001, 32'h0000_00A5, 0);
        chk("t1.ack", bus.ack, 4'b0001);
        chk("t1.q", bus.q, 8'hA5);
        tick(4'b0000, 32'h0000_00A5, 0);
        chk("t1.busy", bus.busy, 0);

        // all requesters persistently active, dropping only in their ack cycle
        do_reset();
        for (int n = 0; n < 40 && gq.size() < 5; n++) begin
            tick(4'hF & ~oh(m_a), 32'h0804_0201, 0);
            if (bus.grant != 0) gq.push_back(bus.grant);
            if (bus.ack != 0) begin
                ack_cyc.push_back(cyc);
                if (ack_cyc.size() == 4) chk("t2.q", bus.q, 8'h0F);
            end
        end
        chk("t2.ngrants", gq.size(), 5);
        chk("t2.nacks", ack_cyc.size(), 4);
        for (int k = 0; k < gq.size(); k++) chk("t2.order", gq[k], oh(k % 4));
        for (int k = 1; k < ack_cyc.size(); k++) chk("t2.spacing", ack_cyc[k] - ack_cyc[k-1], 2);

        // abort during GRANT, then wrap-around search from index 3
        do_reset();
        tick(4'b0100, 32'h0033_0011, 0);
        chk("t3.grant2", bus.grant, 4'b0100);
        tick(4'b0000, 32'h0033_0011, 0);
        chk("t3.noack", bus.ack, 0);
        chk("t3.q", bus.q, 8'h00);
        tick(4'b0101, 32'h0033_0011, 0);
        chk("t3.wrap", bus.grant, 4'b0001);
        tick(4'b0101, 32'h0033_0011, 0);
        tick(4'b0100, 32'h0033_0011, 0);
        tick(4'b0000, 32'h0033_0011, 0);
        tick(4'b0000, 32'h0033_0011, 0);

        // clear coinciding with an apply edge
        do_reset();
        tick(4'b0010, 32'h0000_3C00, 0);
        tick(4'b0010, 32'h0000_3C00, 0);
        tick(4'b0000, 32'h0000_3C00, 0);
        chk("t4.q3c", bus.q, 8'h3C);
        tick(4'b1000, 32'hFF00_0000, 0);
        tick(4'b1000, 32'hFF00_0000, 1);
        chk("t4.ack", bus.ack, 4'b1000);
        chk("t4.qclr", bus.q, 8'h00);
        tick(4'b1001, 32'hFF00_0000, 0);
        chk("t4.ptradv", bus.grant, 4'b0001);
        tick(4'b0001, 32'hFF00_0000, 0);
        tick(4'b0000, 32'hFF00_0000, 0);
        tick(4'b0000, 32'hFF00_0000, 0);

        // asynchronous reset in the middle of GRANT
        do_reset();
        tick(4'b0001, 32'h0000_005A, 0);
        tick(4'b0001, 32'h0000_005A, 0);
        tick(4'b0000, 32'h0000_005A, 0);
        tick(4'b0010, 32'h0000_005A, 0);
        #2 rst = 1'b1;
        #1;
        chk("t5.grant", bus.grant, 0);
        chk("t5.ack", bus.ack, 0);
        chk("t5.busy", bus.busy, 0);
        chk("t5.q", bus.q, 0);
        model_reset();
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
        tick(4'b1001, 32'h0000_0000, 0);
        chk("t5.first", bus.grant, 4'b0001);
        tick(4'b1001, 32'h0000_0000, 0);
        tick(4'b1000, 32'h0000_0000, 0);
        tick(4'b0000, 32'h0000_0000, 0);
        tick(4'b0000, 32'h0000_0000, 0);

        // zero mask handshake
        do_reset();
        tick(4'b0001, 32'h0000_0055, 0);
        tick(4'b0001, 32'h0000_0055, 0);
        tick(4'b0000, 32'h0000_0055, 0);
        tick(4'b0010, 32'h0000_0055, 0);
        tick(4'b0010, 32'h0000_0055, 0);
        chk("t6.ack", bus.ack, 4'b0010);
        chk("t6.q", bus.q, 8'h55);
        tick(4'b0000, 32'h0000_0055, 0);

        // randomized requesters honouring the mask-hold rule, with random aborts and clears
        do_reset();
        pend = '0;
        for (int i = 0; i < 4; i++) pm[i] = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (m_a == i) begin
                    pend[i] = ($urandom % 4 == 0);
                end else if (!pend[i]) begin
                    pm[i] = 8'($urandom);
                    pend[i] = ($urandom % 3 == 0);
                end else if (m_g == i && $urandom % 6 == 0) begin
                    pend[i] = 1'b0;
                end
            end
            rr = pend;
            mm = {pm[3], pm[2], pm[1], pm[0]};
            tick(rr, mm, ($urandom % 20 == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
